sm83_sequencer: RTL and testbench

M-cycle sequencer for the SM83 core. It owns the instruction register (IR) and the micro-step counter that feed the opcode decoder, and times each decoder step as one 4-T-cycle M-cycle. It runs the external memory read/write handshake, evaluates branch conditions, and issues the commit strobe that lets the register file latch results. It sits between the bus interface, the decoder and the register file.

---
 rtl/sm83_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_sm83_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_sequencer.sv
// ---------------------------------------------------------------------------
// sm83_sequencer
//
// M-cycle sequencer for the SM83 core. Holds the instruction register and
// micro-step counter that address the opcode decoder. It times every decoder
// step as one M-cycle of four T-cycles (T0..T3) and runs the memory
// read/write handshake, with T2 wait states. It also evaluates branch
// conditions and issues the register-file commit strobe.
//
// Optional feature macro: SEQ_STEP_WATCHDOG_EN
//   When defined, a sticky 'fault' output is added. Running past step 7
//   without dec_done sets fault and restarts at step 0 with IR forced to NOP.
//   When undefined, the step counter silently wraps 7 -> 0.
//
// Parameters
//   RESET_IR  IR value loaded on reset (default NOP)
//   WAIT_MAX  T2 stalls allowed before a forced continue (0 = unlimited)
//
// Ports
//   clk            in   core clock
//   reset          in   asynchronous active-high reset
//   dec_done       in   decoder: final step of the current opcode
//   dec_is_cond    in   decoder: this step branches on cc
//   dec_next_cond  in   decoder: target step when cc is not met
//   dec_write_mem  in   decoder: this step writes memory
//   flag_z/flag_c  in   Z and C flags
//   mem_rdata      in   external read data
//   mem_ready      in   external access complete (sampled in T2)
//   ir             out  opcode to the decoder
//   step           out  micro-step to the decoder
//   tcycle         out  current T-cycle 0..3
//   mem_rd/mem_wr  out  read / write request (T1..T2 only)
//   mdr            out  latched read data
//   commit         out  register-file latch strobe (T3)
//   cc_met         out  condition result, combinational from ir[4:3]
//   fault          out  (SEQ_STEP_WATCHDOG_EN only) sticky step overrun flag
//   fetch          out  one-clock pulse in the T0 after IR loads
// ---------------------------------------------------------------------------
module sm83_sequencer #(
   parameter logic [7:0]  RESET_IR = 8'h00,
   parameter int unsigned WAIT_MAX = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dec_done,
   input  logic       dec_is_cond,
   input  logic [2:0] dec_next_cond,
   input  logic       dec_write_mem,
   input  logic       flag_z,
   input  logic       flag_c,
   input  logic [7:0] mem_rdata,
   input  logic       mem_ready,
   output logic [7:0] ir,
   output logic [2:0] step,
   output logic [1:0] tcycle,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [7:0] mdr,
   output logic       commit,
   output logic       cc_met,
`ifdef SEQ_STEP_WATCHDOG_EN
   output logic       fault,
`endif
   output logic       fetch
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } tstate_e;

   // Wait limits above 16 bits are truncated; the counter saturates so an
   // unlimited stall never wraps back onto the limit.
   localparam logic [15:0] WAIT_LIM = WAIT_MAX[15:0];

   tstate_e     t_q, t_d;
   logic [15:0] wait_q, wait_d;
   logic [7:0]  ir_q, ir_d;
   logic [2:0]  step_q, step_d;
   logic [7:0]  mdr_q, mdr_d;
   logic        fetch_q, fetch_d;
   logic        wait_hit;
   logic        bus_phase;
`ifdef SEQ_STEP_WATCHDOG_EN
   logic        fault_q, fault_d;
`endif

   // Condition code lives in ir[4:3] for all conditional SM83 opcodes.
   always_comb begin
      cc_met = 1'b0;
      case (ir_q[4:3])
         2'b00:   cc_met = !flag_z;
         2'b01:   cc_met = flag_z;
         2'b10:   cc_met = !flag_c;
         default: cc_met = flag_c;
      endcase
   end

   assign wait_hit  = (WAIT_MAX != 0) && (wait_q == WAIT_LIM);
   assign bus_phase = (t_q == T1) || (t_q == T2);

   always_comb begin
      t_d     = t_q;
      wait_d  = wait_q;
      ir_d    = ir_q;
      step_d  = step_q;
      mdr_d   = mdr_q;
      fetch_d = 1'b0;
`ifdef SEQ_STEP_WATCHDOG_EN
      fault_d = fault_q;
`endif
      case (t_q)
         T0: t_d = T1;
         T1: t_d = T2;
         T2: begin
            if (mem_ready || wait_hit) begin
               t_d = T3;
               // Read data is only meaningful on a read step.
               if (!dec_write_mem) begin
                  mdr_d = mem_rdata;
               end
            end else if (wait_q != 16'hFFFF) begin
               wait_d = wait_q + 16'd1;
            end
         end
         default: begin
            t_d    = T0;
            wait_d = 16'd0;
            if (dec_done) begin
               step_d  = 3'd0;
               ir_d    = mdr_q;
               fetch_d = 1'b1;
`ifdef SEQ_STEP_WATCHDOG_EN
            end else if (step_q == 3'd7) begin
               // Decoder ran off the end of an opcode: restart on NOP.
               fault_d = 1'b1;
               ir_d    = 8'h00;
               step_d  = 3'd0;
`endif
            end else if (dec_is_cond && !cc_met) begin
               step_d = dec_next_cond;
            end else begin
               step_d = step_q + 3'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         t_q     <= T0;
         wait_q  <= 16'd0;
         ir_q    <= RESET_IR;
         step_q  <= 3'd0;
         mdr_q   <= 8'h00;
         fetch_q <= 1'b0;
`ifdef SEQ_STEP_WATCHDOG_EN
         fault_q <= 1'b0;
`endif
      end else begin
         t_q     <= t_d;
         wait_q  <= wait_d;
         ir_q    <= ir_d;
         step_q  <= step_d;
         mdr_q   <= mdr_d;
         fetch_q <= fetch_d;
`ifdef SEQ_STEP_WATCHDOG_EN
         fault_q <= fault_d;
`endif
      end
   end

   assign ir     = ir_q;
   assign step   = step_q;
   assign tcycle = t_q;
   assign mdr    = mdr_q;
   assign mem_rd = bus_phase && !dec_write_mem;
   assign mem_wr = bus_phase && dec_write_mem;
   assign commit = (t_q == T3);
   assign fetch  = fetch_q;
`ifdef SEQ_STEP_WATCHDOG_EN
   assign fault  = fault_q;
`endif

endmodule

// File: tb/tb_sm83_sequencer.sv
module tb_sm83_sequencer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, dec_done, dec_is_cond, dec_write_mem, flag_z, flag_c, mem_ready;
   logic [2:0] dec_next_cond;
   logic [7:0] mem_rdata;

   logic [7:0] ir, mdr, wm_ir, wm_mdr;
   logic [2:0] step, wm_step;
   logic [1:0] tcycle, wm_tcycle;
   logic       mem_rd, mem_wr, commit, cc_met, fetch;
   logic       wm_mem_rd, wm_mem_wr, wm_commit, wm_cc_met, wm_fetch;
`ifdef SEQ_STEP_WATCHDOG_EN
   logic       fault, wm_fault;
`endif

   sm83_sequencer #(.RESET_IR(8'h00), .WAIT_MAX(0)) dut (
      .clk(clk), .reset(reset), .dec_done(dec_done), .dec_is_cond(dec_is_cond),
      .dec_next_cond(dec_next_cond), .dec_write_mem(dec_write_mem),
      .flag_z(flag_z), .flag_c(flag_c), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .ir(ir), .step(step), .tcycle(tcycle), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mdr(mdr), .commit(commit), .cc_met(cc_met),
`ifdef SEQ_STEP_WATCHDOG_EN
      .fault(fault),
`endif
      .fetch(fetch)
   );

   sm83_sequencer #(.RESET_IR(8'h00), .WAIT_MAX(2)) u_wm (
      .clk(clk), .reset(reset), .dec_done(dec_done), .dec_is_cond(dec_is_cond),
      .dec_next_cond(dec_next_cond), .dec_write_mem(dec_write_mem),
      .flag_z(flag_z), .flag_c(flag_c), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .ir(wm_ir), .step(wm_step), .tcycle(wm_tcycle), .mem_rd(wm_mem_rd), .mem_wr(wm_mem_wr),
      .mdr(wm_mdr), .commit(wm_commit), .cc_met(wm_cc_met),
`ifdef SEQ_STEP_WATCHDOG_EN
      .fault(wm_fault),
`endif
      .fetch(wm_fetch)
   );

   int errors = 0;
   int checks = 0;

   // Observed state packed as {ir, step, tcycle, mem_rd, mem_wr, commit, fetch, mdr}.
   logic [24:0] cur, wm_cur, expv;
   assign cur    = {ir, step, tcycle, mem_rd, mem_wr, commit, fetch, mdr};
   assign wm_cur = {wm_ir, wm_step, wm_tcycle, wm_mem_rd, wm_mem_wr, wm_commit, wm_fetch, wm_mdr};

   logic [24:0] exp_q[$];
   logic [2:0]  step_q[$];

   function automatic logic [24:0] vec(input logic [7:0] i, input logic [2:0] s,
                                       input logic [1:0] t, input logic r, input logic w,
                                       input logic c, input logic f, input logic [7:0] m);
      return {i, s, t, r, w, c, f, m};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Runs one M-cycle that ends the opcode, loading v into IR and MDR.
   task automatic load_ir(input logic [7:0] v);
      dec_done = 1'b1; dec_is_cond = 1'b0; dec_write_mem = 1'b0;
      mem_ready = 1'b1; mem_rdata = v;
      repeat (4) tick();
      dec_done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      expv = vec(8'h00, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (cur !== expv) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", cur, expv);
      end
   endtask

   task automatic test_fetch();
      dec_done = 1'b1; dec_is_cond = 1'b0; dec_next_cond = 3'd0; dec_write_mem = 1'b0;
      mem_ready = 1'b1; mem_rdata = 8'h78; flag_z = 1'b0; flag_c = 1'b0;
      do_reset();
      exp_q.push_back(vec(8'h00, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(vec(8'h00, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(vec(8'h00, 3'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h78));
      exp_q.push_back(vec(8'h78, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h78));
      exp_q.push_back(vec(8'h78, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h78));
      exp_q.push_back(vec(8'h78, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h78));
      exp_q.push_back(vec(8'h78, 3'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h78));
      exp_q.push_back(vec(8'h78, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h78));
      for (int k = 1; k <= 8; k++) begin
         tick();
         expv = exp_q.pop_front();
         checks++;
         if (cur !== expv) begin
            errors++;
            $display("FAIL fetch clk%0d got=%h exp=%h", k, cur, expv);
         end
      end
   endtask

   task automatic test_back_to_back_read3();
      logic [1:0] t;
      dec_done = 1'b0; mem_rdata = 8'h3C; mem_ready = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         dec_done = (step == 3'd2);
         t = 2'(k % 4);
         exp_q.push_back(vec((k == 12) ? 8'h3C : 8'h78, (k < 12) ? 3'(k / 4) : 3'd0, t,
                             (t == 2'd1) || (t == 2'd2), 1'b0, (t == 2'd3), (k == 12),
                             (k >= 3) ? 8'h3C : 8'h78));
         tick();
         expv = exp_q.pop_front();
         checks++;
         if (cur !== expv) begin
            errors++;
            $display("FAIL read3 clk%0d got=%h exp=%h", k, cur, expv);
         end
      end
      dec_done = 1'b0;
   endtask

   task automatic test_wait_states();
      dec_done = 1'b1;
      exp_q.push_back(vec(8'h3C, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C));
      exp_q.push_back(vec(8'h3C, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C));
      exp_q.push_back(vec(8'h3C, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C));
      exp_q.push_back(vec(8'h3C, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C));
      exp_q.push_back(vec(8'h3C, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C));
      exp_q.push_back(vec(8'h3C, 3'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5));
      exp_q.push_back(vec(8'hA5, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5));
      for (int k = 1; k <= 7; k++) begin
         mem_ready = !(k >= 3 && k <= 5);
         mem_rdata = (k == 6) ? 8'hA5 : 8'h5A;
         tick();
         expv = exp_q.pop_front();
         checks++;
         if (cur !== expv) begin
            errors++;
            $display("FAIL wait clk%0d got=%h exp=%h", k, cur, expv);
         end
      end
      dec_done = 1'b0; mem_ready = 1'b1;
   endtask

   task automatic test_cond_branch();
      logic [2:0] es;
      for (int r = 0; r < 2; r++) begin
         load_ir(8'h20);
         repeat (4) tick();
         dec_is_cond = 1'b1; dec_next_cond = 3'd3; flag_z = (r == 0);
         #1;
         checks++;
         if (cc_met !== (r != 0)) begin
            errors++;
            $display("FAIL cond_cc run%0d got=%b exp=%b", r, cc_met, (r != 0));
         end
         step_q.push_back((r == 0) ? 3'd3 : 3'd2);
         repeat (4) tick();
         es = step_q.pop_front();
         checks++;
         if (step !== es) begin
            errors++;
            $display("FAIL cond_step run%0d got=%0d exp=%0d", r, step, es);
         end
         dec_is_cond = 1'b0;
      end
   endtask

   task automatic test_cc_table();
      logic [1:0] cc;
      logic [1:0] f;
      logic       e;
      for (int c = 0; c < 4; c++) begin
         cc = 2'(c);
         load_ir({3'b000, cc, 3'b000});
         for (int j = 0; j < 4; j++) begin
            f = 2'(j);
            flag_z = f[0]; flag_c = f[1];
            #1;
            case (cc)
               2'd0:    e = !f[0];
               2'd1:    e = f[0];
               2'd2:    e = !f[1];
               default: e = f[1];
            endcase
            checks++;
            if (cc_met !== e) begin
               errors++;
               $display("FAIL cc_table cc=%0d z=%b c=%b got=%b exp=%b", cc, f[0], f[1], cc_met, e);
            end
         end
      end
   endtask

   task automatic test_write();
      load_ir(8'h40);
      dec_write_mem = 1'b1; dec_done = 1'b0; mem_rdata = 8'hEE; mem_ready = 1'b1;
      exp_q.push_back(vec(8'h40, 3'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40));
      exp_q.push_back(vec(8'h40, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40));
      exp_q.push_back(vec(8'h40, 3'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40));
      exp_q.push_back(vec(8'h40, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40));
      for (int k = 1; k <= 4; k++) begin
         tick();
         expv = exp_q.pop_front();
         checks++;
         if (cur !== expv) begin
            errors++;
            $display("FAIL write clk%0d got=%h exp=%h", k, cur, expv);
         end
      end
      dec_write_mem = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      mem_ready = 1'b0; dec_done = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      #1;
      expv = vec(8'h00, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (cur !== expv) begin
         errors++;
         $display("FAIL reset_mid got=%h exp=%h", cur, expv);
      end
      tick();
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({tcycle, step} !== {2'd0, 3'd0}) begin
         errors++;
         $display("FAIL reset_release got t=%0d s=%0d exp t=0 s=0", tcycle, step);
      end
      tick();
      expv = vec(8'h00, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (cur !== expv) begin
         errors++;
         $display("FAIL reset_resume got=%h exp=%h", cur, expv);
      end
   endtask

   task automatic test_wait_max();
      dec_done = 1'b0; dec_is_cond = 1'b0; dec_write_mem = 1'b0;
      mem_ready = 1'b0; mem_rdata = 8'h11; flag_z = 1'b0;
      do_reset();
      exp_q.push_back(vec(8'h00, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(vec(8'h00, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(vec(8'h00, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(vec(8'h00, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(vec(8'h00, 3'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11));
      exp_q.push_back(vec(8'h00, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11));
      exp_q.push_back(vec(8'h00, 3'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11));
      exp_q.push_back(vec(8'h00, 3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11));
      exp_q.push_back(vec(8'h00, 3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11));
      exp_q.push_back(vec(8'h00, 3'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11));
      for (int k = 1; k <= 10; k++) begin
         tick();
         expv = exp_q.pop_front();
         checks++;
         if (wm_cur !== expv) begin
            errors++;
            $display("FAIL waitmax clk%0d got=%h exp=%h", k, wm_cur, expv);
         end
      end
      checks++;
      if (wm_cc_met !== 1'b1) begin
         errors++;
         $display("FAIL waitmax_cc got=%b exp=1", wm_cc_met);
      end
      checks++;
      if (tcycle !== 2'd2) begin
         errors++;
         $display("FAIL unlimited_wait got t=%0d exp t=2", tcycle);
      end
   endtask

   initial begin
      reset = 1'b1; dec_done = 1'b0; dec_is_cond = 1'b0; dec_next_cond = 3'd0;
      dec_write_mem = 1'b0; flag_z = 1'b0; flag_c = 1'b0;
      mem_rdata = 8'h00; mem_ready = 1'b1;
      test_reset();
      test_fetch();
      test_back_to_back_read3();
      test_wait_states();
      test_cond_branch();
      test_cc_table();
      test_write();
      test_reset_mid_stall();
      test_wait_max();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
